// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: round-robin ownership of the single framebuffer plot port among NREQ drawing clients.
// Optional hold watchdog is compiled in when DRAW_ARB_WATCHDOG_EN is defined.
module draw_port_arbiter #(
   parameter int NREQ     = 4,
   parameter int XW       = 8,
   parameter int YW       = 7,
   parameter int CW       = 3,
   parameter int MAX_HOLD = 4096
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    plot_in,
   input  logic [NREQ*XW-1:0] x_in,
   input  logic [NREQ*YW-1:0] y_in,
   input  logic [NREQ*CW-1:0] colour_in,
   output logic [NREQ-1:0]    gnt,
   output logic [2:0]         gnt_id,
   output logic               busy,
   output logic [XW-1:0]      x_out,
   output logic [YW-1:0]      y_out,
   output logic [CW-1:0]      colour_out,
   output logic               plot_out,
   output logic               timeout_pulse
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [NREQ-1:0] gnt_r, gnt_s;
   logic [2:0]      gnt_id_r, gnt_id_s;
   logic [2:0]      ptr_r, ptr_s;
   logic            busy_r, busy_s;
   logic            plot_r, plot_s;
   logic            timeout_r, timeout_s;
   logic [XW-1:0]   x_r, x_s;
   logic [YW-1:0]   y_r, y_s;
   logic [CW-1:0]   colour_r, colour_s;

   logic [NREQ-1:0] elig_s;
   logic [NREQ-1:0] mask_eff_s;
   logic [NREQ-1:0] pick_oh_s;
   logic [2:0]      pick_id_s;
   logic            pick_found_s;
   int              best_d_s;
   int              dist_s;

   logic            own_req_s;
   logic            own_plot_s;
   logic [XW-1:0]   own_x_s;
   logic [YW-1:0]   own_y_s;
   logic [CW-1:0]   own_colour_s;
   logic            wd_trip_s;

`ifdef DRAW_ARB_WATCHDOG_EN
   localparam int CNTW = $clog2(MAX_HOLD + 1);

   logic [CNTW-1:0] cnt_r, cnt_s;
   logic [NREQ-1:0] mask_r, mask_s;

   assign wd_trip_s  = (state_r == OWN) && own_req_s && (cnt_r == CNTW'(MAX_HOLD - 1));
   assign mask_eff_s = mask_r;

   // A revoked client stays masked until it lets go of req.
   always_comb begin
      cnt_s  = cnt_r;
      mask_s = (mask_r & req) | (wd_trip_s ? gnt_r : {NREQ{1'b0}});
      if ((state_r == IDLE) && pick_found_s) begin
         cnt_s = {CNTW{1'b0}};
      end else if ((state_r == OWN) && (cnt_r != CNTW'(MAX_HOLD))) begin
         cnt_s = cnt_r + CNTW'(1);
      end else begin
         cnt_s = cnt_r;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r  <= {CNTW{1'b0}};
         mask_r <= {NREQ{1'b0}};
      end else begin
         cnt_r  <= cnt_s;
         mask_r <= mask_s;
      end
   end
`else
   // MAX_HOLD only matters to the watchdog build; this term is always false.
   assign wd_trip_s  = (MAX_HOLD < 0);
   assign mask_eff_s = {NREQ{1'b0}};
`endif

   // Owner's stream selected through the one-hot grant, so no index decode is needed.
   always_comb begin
      own_req_s    = 1'b0;
      own_plot_s   = 1'b0;
      own_x_s      = {XW{1'b0}};
      own_y_s      = {YW{1'b0}};
      own_colour_s = {CW{1'b0}};
      for (int j = 0; j < NREQ; j++) begin
         own_req_s    = own_req_s  | (gnt_r[j] & req[j]);
         own_plot_s   = own_plot_s | (gnt_r[j] & plot_in[j]);
         own_x_s      = own_x_s      | (x_in[j*XW +: XW]      & {XW{gnt_r[j]}});
         own_y_s      = own_y_s      | (y_in[j*YW +: YW]      & {YW{gnt_r[j]}});
         own_colour_s = own_colour_s | (colour_in[j*CW +: CW] & {CW{gnt_r[j]}});
      end
   end

   // Winner is the eligible client at the smallest distance past the pointer.
   always_comb begin
      elig_s    = req & ~mask_eff_s;
      best_d_s  = NREQ;
      dist_s    = 0;
      pick_id_s = ptr_r;
      pick_oh_s = {NREQ{1'b0}};
      for (int j = 0; j < NREQ; j++) begin
         logic take;
         dist_s    = j - int'(ptr_r) - 1;
         dist_s    = (dist_s < 0) ? dist_s + NREQ : dist_s;
         take      = elig_s[j] && (dist_s < best_d_s);
         best_d_s  = take ? dist_s : best_d_s;
         pick_id_s = take ? 3'(j) : pick_id_s;
         pick_oh_s = take ? (NREQ'(1) << j) : pick_oh_s;
      end
      pick_found_s = (best_d_s < NREQ);
   end

   always_comb begin
      state_s    = state_r;
      gnt_s      = gnt_r;
      gnt_id_s   = gnt_id_r;
      ptr_s      = ptr_r;
      busy_s     = busy_r;
      plot_s     = 1'b0;
      timeout_s  = 1'b0;
      x_s        = x_r;
      y_s        = y_r;
      colour_s   = colour_r;
      case (state_r)
         IDLE: begin
            gnt_s  = {NREQ{1'b0}};
            busy_s = 1'b0;
            if (pick_found_s) begin
               state_s  = OWN;
               gnt_s    = pick_oh_s;
               gnt_id_s = pick_id_s;
               ptr_s    = pick_id_s;
               busy_s   = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         OWN: begin
            plot_s   = own_plot_s;
            x_s      = own_x_s;
            y_s      = own_y_s;
            colour_s = own_colour_s;
            if (!own_req_s) begin
               state_s = GAP;
               gnt_s   = {NREQ{1'b0}};
               busy_s  = 1'b0;
            end else if (wd_trip_s) begin
               state_s   = GAP;
               gnt_s     = {NREQ{1'b0}};
               busy_s    = 1'b0;
               timeout_s = 1'b1;
            end else begin
               state_s = OWN;
            end
         end
         GAP: begin
            state_s = IDLE;
            gnt_s   = {NREQ{1'b0}};
            busy_s  = 1'b0;
         end
         default: begin
            state_s = IDLE;
            gnt_s   = {NREQ{1'b0}};
            busy_s  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // All outputs leave from flops; pointer mirrors the last granted index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_r     <= {NREQ{1'b0}};
         gnt_id_r  <= 3'(NREQ - 1);
         ptr_r     <= 3'(NREQ - 1);
         busy_r    <= 1'b0;
         plot_r    <= 1'b0;
         timeout_r <= 1'b0;
         x_r       <= {XW{1'b0}};
         y_r       <= {YW{1'b0}};
         colour_r  <= {CW{1'b0}};
      end else begin
         gnt_r     <= gnt_s;
         gnt_id_r  <= gnt_id_s;
         ptr_r     <= ptr_s;
         busy_r    <= busy_s;
         plot_r    <= plot_s;
         timeout_r <= timeout_s;
         x_r       <= x_s;
         y_r       <= y_s;
         colour_r  <= colour_s;
      end
   end

   assign gnt           = gnt_r;
   assign gnt_id        = gnt_id_r;
   assign busy          = busy_r;
   assign plot_out      = plot_r;
   assign timeout_pulse = timeout_r;
   assign x_out         = x_r;
   assign y_out         = y_r;
   assign colour_out    = colour_r;

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Scoreboard bench for draw_port_arbiter: expected grants and pixels are queued by the stimulus,
// a negedge monitor pops and compares them. Watchdog checks follow DRAW_ARB_WATCHDOG_EN.
module tb_draw_port_arbiter;
   localparam int NREQ     = 4;
   localparam int XW       = 8;
   localparam int YW       = 7;
   localparam int CW       = 3;
   localparam int MAX_HOLD = 16;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      plot_in;
   logic [NREQ*XW-1:0]   x_in;
   logic [NREQ*YW-1:0]   y_in;
   logic [NREQ*CW-1:0]   colour_in;
   logic [NREQ-1:0]      gnt;
   logic [2:0]           gnt_id;
   logic                 busy;
   logic [XW-1:0]        x_out;
   logic [YW-1:0]        y_out;
   logic [CW-1:0]        colour_out;
   logic                 plot_out;
   logic                 timeout_pulse;

   typedef struct { int id; int gap; } gexp_t;
   typedef struct { int x; int y; int c; } pexp_t;
   gexp_t gq[$];
   pexp_t pq[$];
   gexp_t ge;
   pexp_t pe;

   int total = 0;
   int bad   = 0;
   int low_cnt = 0;
   int pulses  = 0;
   int errs;
   logic [NREQ-1:0] prev_gnt = 4'd0;

   always #5 clk = ~clk;

   draw_port_arbiter #(
      .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .plot_in(plot_in),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
      .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
      .plot_out(plot_out), .timeout_pulse(timeout_pulse)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_g(input int id, input int gap);
      gexp_t g;
      g.id = id;
      g.gap = gap;
      gq.push_back(g);
   endtask

   task automatic set_pix(input int k, input int x, input int y, input int c);
      x_in[k*XW +: XW]      = XW'(x);
      y_in[k*YW +: YW]      = YW'(y);
      colour_in[k*CW +: CW] = CW'(c);
   endtask

   task automatic plot_exp(input int k, input int x, input int y, input int c);
      pexp_t p;
      set_pix(k, x, y, c);
      plot_in[k] = 1'b1;
      p.x = x;
      p.y = y;
      p.c = c;
      pq.push_back(p);
   endtask

   task automatic wait_gnt(input string nm);
      for (int i = 0; i < 20 && gnt == 4'd0; i++) cyc();
      chk(nm, int'(gnt != 4'd0), 1);
   endtask

   // Monitor: pixel writes, new grants with handover gap, watchdog pulses.
   always @(negedge clk) begin
      if (timeout_pulse) pulses++;
      if (plot_out) begin
         if (pq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pix_unexpected x_out=%0d want=no_write", x_out);
         end else begin
            pe = pq.pop_front();
            chk("pix_x", int'(x_out), pe.x);
            chk("pix_y", int'(y_out), pe.y);
            chk("pix_c", int'(colour_out), pe.c);
         end
      end
      if (gnt != 4'd0 && prev_gnt == 4'd0) begin
         if (gq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL gnt_unexpected gnt=%0d want=none", gnt);
         end else begin
            ge = gq.pop_front();
            chk("gnt_id", int'(gnt_id), ge.id);
            chk("gnt_onehot", int'(gnt), 1 << ge.id);
            if (ge.gap >= 0) chk("gnt_gap", low_cnt, ge.gap);
         end
      end
      low_cnt  = (gnt == 4'd0) ? low_cnt + 1 : 0;
      prev_gnt = gnt;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running want=done");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset_n   = 1'b1;
      req       = 4'd0;
      plot_in   = 4'd0;
      x_in      = '0;
      y_in      = '0;
      colour_in = '0;
      #1 reset_n = 1'b0;
      cyc(2);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_plot", int'(plot_out), 0);
      chk("rst_gnt_id", int'(gnt_id), 3);
      chk("rst_x", int'(x_out), 0);
      chk("rst_timeout", int'(timeout_pulse), 0);
      reset_n = 1'b1;
      cyc();

      // single client, one-cycle grant and pixel latency
      req = 4'b0100;
      push_g(2, -1);
      cyc();
      chk("single_gnt", int'(gnt), 4);
      chk("single_gnt_id", int'(gnt_id), 2);
      chk("single_busy", int'(busy), 1);
      plot_exp(2, 40, 30, 5);
      cyc();
      chk("single_plot", int'(plot_out), 1);
      chk("single_x", int'(x_out), 40);
      chk("single_y", int'(y_out), 30);
      chk("single_c", int'(colour_out), 5);
      plot_in = 4'd0;
      req     = 4'd0;
      cyc();
      chk("single_release", int'(gnt), 0);
      chk("single_busy_low", int'(busy), 0);
      cyc(3);

      // isolation: client 3 plots while client 1 owns
      req = 4'b0010;
      push_g(1, -1);
      cyc();
      chk("iso_gnt", int'(gnt), 2);
      plot_exp(1, 11, 12, 3);
      set_pix(3, 99, 99, 7);
      plot_in[3] = 1'b1;
      cyc();
      plot_exp(1, 12, 13, 4);
      cyc();
      plot_exp(1, 13, 14, 5);
      req = 4'd0;
      cyc();
      chk("iso_drop_gnt", int'(gnt), 0);
      chk("iso_drop_plot", int'(plot_out), 1);
      chk("iso_drop_x", int'(x_out), 13);
      plot_in[1] = 1'b0;
      cyc(3);
      plot_in = 4'd0;
      cyc();

      // reset asserted mid-transaction
      req = 4'b0010;
      push_g(1, -1);
      cyc();
      chk("mid_gnt", int'(gnt), 2);
      plot_exp(1, 21, 22, 6);
      cyc(2);
      chk("mid_plot_before", int'(plot_out), 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_gnt", int'(gnt), 0);
      chk("mid_rst_plot", int'(plot_out), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_gnt_id", int'(gnt_id), 3);
      req     = 4'd0;
      plot_in = 4'd0;
      cyc();
      reset_n = 1'b1;
      cyc();

      // contention: 0,1,2,3,0 with a two-cycle handover each time
      req = 4'b1111;
      push_g(0, -1);
      push_g(1, 2);
      push_g(2, 2);
      push_g(3, 2);
      push_g(0, 2);
      for (int r = 0; r < 5; r++) begin
         wait_gnt("rr_wait");
         chk("rr_owner", int'(gnt_id), r % 4);
         cyc(4);
         if (r == 4) req = 4'd0;
         else req[r % 4] = 1'b0;
         cyc();
         if (r != 4) req[r % 4] = 1'b1;
      end
      cyc(4);

      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      cyc();
      req = 4'b0011;
      push_g(0, -1);
`ifdef DRAW_ARB_WATCHDOG_EN
      push_g(1, 2);
      wait_gnt("wd_first");
      cyc(15);
      chk("wd_hold_gnt", int'(gnt), 1);
      chk("wd_no_pulse_yet", int'(timeout_pulse), 0);
      cyc();
      chk("wd_pulse", int'(timeout_pulse), 1);
      chk("wd_revoked", int'(gnt), 0);
      cyc();
      chk("wd_pulse_one_cycle", int'(timeout_pulse), 0);
      cyc();
      chk("wd_next_owner", int'(gnt), 2);
      cyc(3);
      req = 4'b0001;
      cyc(2);
      errs = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (gnt != 4'd0) errs++;
      end
      chk("wd_masked", errs, 0);
      req = 4'd0;
      cyc();
      req = 4'b0001;
      push_g(0, -1);
      wait_gnt("wd_regrant");
      chk("wd_regrant_gnt", int'(gnt), 1);
      req = 4'd0;
      cyc(4);
      chk("wd_pulse_count", pulses, 1);
`else
      push_g(1, 2);
      wait_gnt("nowd_first");
      errs = 0;
      for (int i = 0; i < 10000; i++) begin
         cyc();
         if (gnt != 4'b0001 || timeout_pulse) errs++;
      end
      chk("nowd_hold", errs, 0);
      req = 4'b0010;
      cyc();
      wait_gnt("nowd_next");
      chk("nowd_next_gnt", int'(gnt), 2);
      req = 4'd0;
      cyc(4);
      chk("nowd_pulse_count", pulses, 0);
`endif

      cyc(2);
      chk("pix_queue_empty", pq.size(), 0);
      chk("gnt_queue_empty", gq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
